// File: rtl/fsm_pkg.sv
// State encodings for the NoC network interface controllers.
package fsm_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECV,
    ST_DELIVER
  } ni_init_states_e;
endpackage

// File: rtl/ni_pkg.sv
// Packet geometry and flit helpers shared by the initiator- and target-side NIs.
package ni_pkg;
  localparam int TOTAL_FLITS = 4;
  localparam int FLIT_WIDTH  = 16;
  localparam int BODY_FLITS  = TOTAL_FLITS - 2;
  localparam int BEAT_W      = $clog2(TOTAL_FLITS);

  typedef logic [FLIT_WIDTH-1:0]                   flit_t;
  typedef logic [BEAT_W-1:0]                       beat_t;
  typedef logic [TOTAL_FLITS-1:0][FLIT_WIDTH-1:0]  flit_vec_t;

  typedef struct packed {
    flit_t                  head_flit;
    flit_t [BODY_FLITS-1:0] body_flit;
    flit_t                  tail_flit;
  } req_packet_s;

  typedef struct packed {
    flit_t                  head_flit;
    flit_t [BODY_FLITS-1:0] body_flit;
    flit_t                  tail_flit;
  } resp_packet_s;

  // Viewing a packet as flit_vec_t puts head at the top word and tail at word 0,
  // so beat order (head, highest body first, tail) is a simple reversal.
  function automatic beat_t flit_sel(input beat_t beat);
    return beat_t'(TOTAL_FLITS - 1) - beat;
  endfunction
endpackage

// File: rtl/ni_initiator_if.sv
// Request/response and flit handshakes of the initiator NI; slave = the NI, master = PE plus router.
interface ni_initiator_if;
  import ni_pkg::*;

  logic         req_valid;
  logic         req_ready;
  req_packet_s  req_pkt;
  logic         resp_valid;
  logic         resp_ready;
  resp_packet_s resp_pkt;
  flit_t        o_flit;
  logic         o_flit_valid;
  logic         i_flit_ready;
  flit_t        i_flit;
  logic         i_flit_valid;
  logic         o_flit_ready;

  modport slave (
    input  req_valid, req_pkt, resp_ready, i_flit_ready, i_flit, i_flit_valid,
    output req_ready, resp_valid, resp_pkt, o_flit, o_flit_valid, o_flit_ready
  );

  modport master (
    output req_valid, req_pkt, resp_ready, i_flit_ready, i_flit, i_flit_valid,
    input  req_ready, resp_valid, resp_pkt, o_flit, o_flit_valid, o_flit_ready
  );
endinterface

// File: rtl/ni_initiator.sv
// Initiator NI: serialises one request packet into flits, collects the response flits,
// and hands the assembled response back to the master. One transaction in flight.
//
// state        | meaning
// ST_IDLE      | ready for a request from the master
// ST_SEND      | driving request flits to the router, beat selects the flit
// ST_WAIT_RESP | waiting for the response head flit
// ST_RECV      | collecting response body/tail flits
// ST_DELIVER   | holding the assembled response until the master takes it
module ni_initiator
  import ni_pkg::*;
  import fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          resetn,
  ni_initiator_if.slave bus,
  output logic          busy,
  output logic          timeout_err
);
  localparam int               TMO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam beat_t            BEAT_LAST = beat_t'(TOTAL_FLITS - 1);

  ni_init_states_e  state;
  beat_t            beat;
  logic [TMO_W-1:0] tmo_cnt;
  flit_vec_t        req_words;
  flit_vec_t        resp_words;

  // Both are muxes of registers only, so they stay stable under backpressure.
  assign bus.o_flit   = bus.o_flit_valid ? req_words[flit_sel(beat)] : '0;
  assign bus.resp_pkt = bus.resp_valid ? resp_packet_s'(resp_words) : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      beat             <= '0;
      tmo_cnt          <= '0;
      req_words        <= '0;
      resp_words       <= '0;
      bus.req_ready    <= 1'b1;
      bus.o_flit_valid <= 1'b0;
      bus.o_flit_ready <= 1'b0;
      bus.resp_valid   <= 1'b0;
      busy             <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            req_words        <= flit_vec_t'(bus.req_pkt);
            beat             <= '0;
            state            <= ST_SEND;
            bus.req_ready    <= 1'b0;
            bus.o_flit_valid <= 1'b1;
            busy             <= 1'b1;
          end
        end
        ST_SEND: begin
          if (bus.o_flit_valid && bus.i_flit_ready) begin
            if (beat == BEAT_LAST) begin
              beat             <= '0;
              tmo_cnt          <= '0;
              state            <= ST_WAIT_RESP;
              bus.o_flit_valid <= 1'b0;
              bus.o_flit_ready <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        ST_WAIT_RESP, ST_RECV: begin
          // The pulse cycle has o_flit_ready low, so nothing is accepted while aborting.
          if (timeout_err) begin
            state         <= ST_IDLE;
            beat          <= '0;
            tmo_cnt       <= '0;
            resp_words    <= '0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
          end else if (bus.i_flit_valid && bus.o_flit_ready) begin
            resp_words[flit_sel(beat)] <= bus.i_flit;
            tmo_cnt                    <= '0;
            if (beat == BEAT_LAST) begin
              beat             <= '0;
              state            <= ST_DELIVER;
              bus.o_flit_ready <= 1'b0;
              bus.resp_valid   <= 1'b1;
            end else begin
              beat  <= beat + 1'b1;
              state <= ST_RECV;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (tmo_cnt == TMO_LAST) begin
              timeout_err      <= 1'b1;
              bus.o_flit_ready <= 1'b0;
            end
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DELIVER: begin
          if (bus.resp_valid && bus.resp_ready) begin
            state          <= ST_IDLE;
            resp_words     <= '0;
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            busy           <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
